vga_fb_reader: RTL

VGA_FB_READER -- requirements
Module: vga_fb_reader

---
 rtl/vga_fb_reader.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_reader.sv
// Double-buffered line fetcher between a word-addressed frame buffer and a VGA timing generator.
// Define VGA_FB_TESTPAT_EN to add a test_mode input that overrides the pixel output with an x/y pattern.
module vga_fb_reader #(
    parameter int          H_RES   = 800,
    parameter int          V_RES   = 600,
    parameter logic [19:0] FB_BASE = 20'h00000
) (
    input  logic        vga_clk,
    input  logic        resetn,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
`ifdef VGA_FB_TESTPAT_EN
    input  logic        test_mode,
`endif
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        underrun
);

    localparam int              IW     = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int              LW     = $clog2(2 * H_RES);
    localparam logic [10:0]     H_LIM  = 11'(H_RES);
    localparam logic [10:0]     V_LIM  = 11'(V_RES);
    localparam logic [10:0]     V_LAST = 11'(V_RES - 1);
    localparam logic [IW-1:0]   I_LAST = IW'(H_RES - 1);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t          state_q, state_d;
    logic [9:0]      y_prev_q, y_prev_d;
    logic [9:0]      tgt_q, tgt_d;
    logic [IW-1:0]   i_q, i_d;
    logic            mem_req_q, mem_req_d;
    logic [19:0]     mem_addr_q, mem_addr_d;
    logic [9:0]      last_line_q, last_line_d;
    logic            last_valid_q, last_valid_d;
    logic [1:0][9:0] bank_line_q, bank_line_d;
    logic [1:0]      bank_valid_q, bank_valid_d;
    logic            restart_q, restart_d;
    logic            underrun_q, underrun_d;
    logic            vis_q, vis_d;

    logic            line_event;
    logic [9:0]      tgt_new;
    logic            start_ok;
    logic            do_start;
    logic [9:0]      start_tgt;
    logic            wr_en;
    logic [LW-1:0]   wr_idx;
    logic [LW-1:0]   rd_idx;
    logic            in_view;
    logic [9:0]      x_c;
    logic [23:0]     pix_q;
    logic            unused_rdata_hi;

    assign unused_rdata_hi = ^mem_rdata[31:24];

    assign line_event = (y != y_prev_q);
    assign tgt_new    = ({1'b0, y} < V_LAST) ? (y + 10'd1) : 10'd0;
    assign start_ok   = !last_valid_q || (tgt_new != last_line_q);
    assign in_view    = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    assign x_c        = ({1'b0, x} < H_LIM) ? x : 10'd0;

    // Bank 1 occupies the upper half of the single line-buffer array.
    assign rd_idx = y[0]     ? (LW'(H_RES) + LW'(x_c)) : LW'(x_c);
    assign wr_idx = tgt_q[0] ? (LW'(H_RES) + LW'(i_q)) : LW'(i_q);

    always_comb begin
        state_d      = state_q;
        y_prev_d     = y;
        tgt_d        = tgt_q;
        i_d          = i_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        last_line_d  = last_line_q;
        last_valid_d = last_valid_q;
        bank_line_d  = bank_line_q;
        bank_valid_d = bank_valid_q;
        restart_d    = restart_q;
        underrun_d   = underrun_q;
        do_start     = 1'b0;
        start_tgt    = tgt_new;
        wr_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (line_event && start_ok) begin
                    do_start  = 1'b1;
                    start_tgt = tgt_new;
                end else if (restart_q) begin
                    do_start  = 1'b1;
                    start_tgt = tgt_q;
                end
            end
            FETCH: begin
                if (line_event) begin
                    // Abort: drop request for a cycle, then refetch the new target from i=0.
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    last_valid_d = 1'b0;
                    underrun_d   = 1'b1;
                    tgt_d        = tgt_new;
                    restart_d    = 1'b1;
                    i_d          = '0;
                end else if (mem_ack) begin
                    wr_en = 1'b1;
                    if (i_q == I_LAST) begin
                        state_d                = IDLE;
                        mem_req_d              = 1'b0;
                        i_d                    = '0;
                        last_line_d            = tgt_q;
                        last_valid_d           = 1'b1;
                        bank_line_d[tgt_q[0]]  = tgt_q;
                        bank_valid_d[tgt_q[0]] = 1'b1;
                    end else begin
                        i_d        = i_q + IW'(1);
                        mem_addr_d = mem_addr_q + 20'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_start) begin
            state_d                    = FETCH;
            tgt_d                      = start_tgt;
            i_d                        = '0;
            mem_req_d                  = 1'b1;
            mem_addr_d                 = FB_BASE + 20'(start_tgt) * 20'(H_RES);
            restart_d                  = 1'b0;
            bank_valid_d[start_tgt[0]] = 1'b0;
        end

        vis_d = in_view && bank_valid_q[y[0]] && (bank_line_q[y[0]] == y);
    end

    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            y_prev_q     <= '0;
            tgt_q        <= '0;
            i_q          <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            last_line_q  <= '0;
            last_valid_q <= 1'b0;
            bank_line_q  <= '0;
            bank_valid_q <= '0;
            restart_q    <= 1'b0;
            underrun_q   <= 1'b0;
            vis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_prev_q     <= y_prev_d;
            tgt_q        <= tgt_d;
            i_q          <= i_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            last_line_q  <= last_line_d;
            last_valid_q <= last_valid_d;
            bank_line_q  <= bank_line_d;
            bank_valid_q <= bank_valid_d;
            restart_q    <= restart_d;
            underrun_q   <= underrun_d;
            vis_q        <= vis_d;
        end
    end

    logic [23:0] lb [0:2*H_RES-1];

    always_ff @(posedge vga_clk) begin
        if (wr_en) begin
            lb[wr_idx] <= mem_rdata[23:0];
        end
        pix_q <= lb[rd_idx];
    end

    logic [23:0] rgb;

`ifdef VGA_FB_TESTPAT_EN
    logic        tm_q, tm_d;
    logic [23:0] pat_q, pat_d;

    assign tm_d  = test_mode && in_view;
    assign pat_d = {x[7:0], y[7:0], x[7:0] ^ y[7:0]};

    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            tm_q  <= 1'b0;
            pat_q <= '0;
        end else begin
            tm_q  <= tm_d;
            pat_q <= pat_d;
        end
    end

    assign rgb = tm_q ? pat_q : (vis_q ? pix_q : 24'h0);
`else
    assign rgb = vis_q ? pix_q : 24'h0;
`endif

    assign {vga_r, vga_g, vga_b} = rgb;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign underrun = underrun_q;

endmodule
